// File: rtl/machine_control_unit_pkg.sv
// Shared definitions for the machine control unit and the CSR file:
// FSM state encodings, mcause codes, PC-source encodings and a small
// helper that classifies misaligned causes.
// Optional feature macro: MCU_INTERRUPTS_EN (adds the WFI_WAIT state).
package mcu_pkg;

  // PC mux select encodings
  localparam logic [1:0] BOOT_PC_SEL = 2'b00;
  localparam logic [1:0] EPC_PC_SEL  = 2'b01;
  localparam logic [1:0] TRAP_PC_SEL = 2'b10;
  localparam logic [1:0] NEXT_PC_SEL = 2'b11;

  // mcause codes (exceptions and interrupts share the 4-bit field)
  localparam logic [3:0] CAUSE_MISALIGNED_INSTR = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL          = 4'd2;
  localparam logic [3:0] CAUSE_EBREAK           = 4'd3;
  localparam logic [3:0] CAUSE_MISALIGNED_LOAD  = 4'd4;
  localparam logic [3:0] CAUSE_MISALIGNED_STORE = 4'd6;
  localparam logic [3:0] CAUSE_ECALL            = 4'd11;
  localparam logic [3:0] CAUSE_MSI              = 4'd3;
  localparam logic [3:0] CAUSE_MTI              = 4'd7;
  localparam logic [3:0] CAUSE_MEI              = 4'd11;

  typedef enum logic [2:0] {
    ST_RESET       = 3'd0,
    ST_OPERATING   = 3'd1,
    ST_TRAP_TAKEN  = 3'd2,
    ST_TRAP_RETURN = 3'd3
`ifdef MCU_INTERRUPTS_EN
    , ST_WFI_WAIT  = 3'd4
`endif
  } state_t;

  // Exceptions whose mtval must carry the faulting address
  function automatic logic is_misaligned_cause(input logic [3:0] cause);
    return (cause == CAUSE_MISALIGNED_INSTR) ||
           (cause == CAUSE_MISALIGNED_LOAD)  ||
           (cause == CAUSE_MISALIGNED_STORE);
  endfunction

endpackage

// File: rtl/machine_control_unit_if.sv
// Bus between the decoder/CSR side (master) and the machine control unit
// (slave): trap request flags in, trap/return strobes out.
// Interrupt lines exist only when MCU_INTERRUPTS_EN is defined.
interface machine_control_unit_if;
`ifdef MCU_INTERRUPTS_EN
  logic mie_in;
  logic meie_in, mtie_in, msie_in;
  logic meip_in, mtip_in, msip_in;
`endif
  logic       illegal_instr_in;
  logic       misaligned_instr_in;
  logic       misaligned_load_in;
  logic       misaligned_store_in;
  logic       ecall_in;
  logic       ebreak_in;
  logic       mret_in;
  logic       wfi_in;
  logic       trap_taken_out;
  logic       i_or_e_out;
  logic [3:0] cause_out;
  logic       set_epc_out;
  logic       set_cause_out;
  logic       mie_clear_out;
  logic       mie_set_out;
  logic       misaligned_exception_out;
  logic       instret_inc_out;
  logic [1:0] pc_src_out;
  logic       flush_out;

  modport master (
`ifdef MCU_INTERRUPTS_EN
    output mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in,
`endif
    output illegal_instr_in, misaligned_instr_in, misaligned_load_in,
    output misaligned_store_in, ecall_in, ebreak_in, mret_in, wfi_in,
    input  trap_taken_out, i_or_e_out, cause_out, set_epc_out, set_cause_out,
    input  mie_clear_out, mie_set_out, misaligned_exception_out,
    input  instret_inc_out, pc_src_out, flush_out
  );

  modport slave (
`ifdef MCU_INTERRUPTS_EN
    input  mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in,
`endif
    input  illegal_instr_in, misaligned_instr_in, misaligned_load_in,
    input  misaligned_store_in, ecall_in, ebreak_in, mret_in, wfi_in,
    output trap_taken_out, i_or_e_out, cause_out, set_epc_out, set_cause_out,
    output mie_clear_out, mie_set_out, misaligned_exception_out,
    output instret_inc_out, pc_src_out, flush_out
  );
endinterface

// File: rtl/machine_control_unit_trap_cause_encoder.sv
// trap_cause_encoder: combinational priority encoder for trap requests.
// Interrupts (already masked by their enables and mstatus.MIE) win over
// exceptions. Ports: exception flags, masked irq_mei/msi/mti in;
// valid, i_or_e (1=interrupt) and cause out.
module trap_cause_encoder
  import mcu_pkg::*;
(
  input  logic       misaligned_instr,
  input  logic       illegal_instr,
  input  logic       ebreak,
  input  logic       ecall,
  input  logic       misaligned_load,
  input  logic       misaligned_store,
  input  logic       irq_mei,
  input  logic       irq_msi,
  input  logic       irq_mti,
  output logic       valid,
  output logic       i_or_e,
  output logic [3:0] cause
);

  // Fixed-priority selection of the winning trap source
  always_comb begin
    valid  = 1'b1;
    i_or_e = 1'b0;
    cause  = 4'd0;
    if (irq_mei) begin
      i_or_e = 1'b1;
      cause  = CAUSE_MEI;
    end else if (irq_msi) begin
      i_or_e = 1'b1;
      cause  = CAUSE_MSI;
    end else if (irq_mti) begin
      i_or_e = 1'b1;
      cause  = CAUSE_MTI;
    end else if (misaligned_instr) begin
      cause  = CAUSE_MISALIGNED_INSTR;
    end else if (illegal_instr) begin
      cause  = CAUSE_ILLEGAL;
    end else if (ebreak) begin
      cause  = CAUSE_EBREAK;
    end else if (ecall) begin
      cause  = CAUSE_ECALL;
    end else if (misaligned_load) begin
      cause  = CAUSE_MISALIGNED_LOAD;
    end else if (misaligned_store) begin
      cause  = CAUSE_MISALIGNED_STORE;
    end else begin
      valid  = 1'b0;
    end
  end

endmodule

// File: rtl/machine_control_unit.sv
// machine_control_unit: trap/return sequencer for the RV32I execute stage.
// Ports: clk_in, rst_n_in (async active-low) and a machine_control_unit_if
// slave carrying trap flags in and PC-select / flush / CSR strobes out.
// Optional feature macro: MCU_INTERRUPTS_EN (interrupt lines, WFI_WAIT).
module machine_control_unit
  import mcu_pkg::*;
(
  input logic                   clk_in,
  input logic                   rst_n_in,
  machine_control_unit_if.slave bus
);

  state_t     state_r, next_state_s;
  logic [3:0] cause_r;
  logic       i_or_e_r;
  logic       mis_flag_r;

  logic       irq_mei_s, irq_msi_s, irq_mti_s, wake_s;
  logic       enc_valid_s, enc_i_or_e_s;
  logic [3:0] enc_cause_s;

  logic       trap_taken_s, set_epc_s, set_cause_s, mie_clear_s, mie_set_s;
  logic       mis_exc_s, instret_inc_s, flush_s;
  logic [1:0] pc_src_s;

`ifdef MCU_INTERRUPTS_EN
  assign irq_mei_s = bus.mie_in & bus.meie_in & bus.meip_in;
  assign irq_msi_s = bus.mie_in & bus.msie_in & bus.msip_in;
  assign irq_mti_s = bus.mie_in & bus.mtie_in & bus.mtip_in;
  // WFI wakes on any enabled pending line even with global MIE clear
  assign wake_s    = (bus.meie_in & bus.meip_in) | (bus.msie_in & bus.msip_in) |
                     (bus.mtie_in & bus.mtip_in);
`else
  assign irq_mei_s = 1'b0;
  assign irq_msi_s = 1'b0;
  assign irq_mti_s = 1'b0;
  assign wake_s    = 1'b0;
`endif

  trap_cause_encoder u_enc (
    .misaligned_instr (bus.misaligned_instr_in),
    .illegal_instr    (bus.illegal_instr_in),
    .ebreak           (bus.ebreak_in),
    .ecall            (bus.ecall_in),
    .misaligned_load  (bus.misaligned_load_in),
    .misaligned_store (bus.misaligned_store_in),
    .irq_mei          (irq_mei_s),
    .irq_msi          (irq_msi_s),
    .irq_mti          (irq_mti_s),
    .valid            (enc_valid_s),
    .i_or_e           (enc_i_or_e_s),
    .cause            (enc_cause_s)
  );

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r <= ST_RESET;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Trap cause capture on the OPERATING -> TRAP_TAKEN edge; held otherwise
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cause_r    <= 4'd0;
      i_or_e_r   <= 1'b0;
      mis_flag_r <= 1'b0;
    end else if ((state_r == ST_OPERATING) && enc_valid_s) begin
      cause_r    <= enc_cause_s;
      i_or_e_r   <= enc_i_or_e_s;
      mis_flag_r <= ~enc_i_or_e_s & is_misaligned_cause(enc_cause_s);
    end else begin
      cause_r    <= cause_r;
      i_or_e_r   <= i_or_e_r;
      mis_flag_r <= mis_flag_r;
    end
  end

  // Next-state and output decode; instruction flags only matter in OPERATING
  always_comb begin
    next_state_s  = state_r;
    trap_taken_s  = 1'b0;
    set_epc_s     = 1'b0;
    set_cause_s   = 1'b0;
    mie_clear_s   = 1'b0;
    mie_set_s     = 1'b0;
    mis_exc_s     = 1'b0;
    instret_inc_s = 1'b0;
    pc_src_s      = NEXT_PC_SEL;
    flush_s       = 1'b0;
    case (state_r)
      ST_RESET: begin
        pc_src_s     = BOOT_PC_SEL;
        flush_s      = 1'b1;
        next_state_s = ST_OPERATING;
      end
      ST_OPERATING: begin
        trap_taken_s = enc_valid_s;
`ifdef MCU_INTERRUPTS_EN
        instret_inc_s = ~enc_valid_s & ~bus.wfi_in;
`else
        instret_inc_s = ~enc_valid_s;
`endif
        if (enc_valid_s) begin
          next_state_s = ST_TRAP_TAKEN;
        end else if (bus.mret_in) begin
          next_state_s = ST_TRAP_RETURN;
`ifdef MCU_INTERRUPTS_EN
        end else if (bus.wfi_in) begin
          next_state_s = ST_WFI_WAIT;
`endif
        end else begin
          next_state_s = ST_OPERATING;
        end
      end
      ST_TRAP_TAKEN: begin
        set_epc_s    = 1'b1;
        set_cause_s  = 1'b1;
        mie_clear_s  = 1'b1;
        mis_exc_s    = mis_flag_r;
        pc_src_s     = TRAP_PC_SEL;
        flush_s      = 1'b1;
        next_state_s = ST_OPERATING;
      end
      ST_TRAP_RETURN: begin
        mie_set_s    = 1'b1;
        pc_src_s     = EPC_PC_SEL;
        flush_s      = 1'b1;
        next_state_s = ST_OPERATING;
      end
`ifdef MCU_INTERRUPTS_EN
      ST_WFI_WAIT: begin
        flush_s = 1'b1;
        if (wake_s) begin
          next_state_s = ST_OPERATING;
        end else begin
          next_state_s = ST_WFI_WAIT;
        end
      end
`endif
      default: begin
        pc_src_s     = BOOT_PC_SEL;
        flush_s      = 1'b1;
        next_state_s = ST_RESET;
      end
    endcase
  end

  assign bus.trap_taken_out           = trap_taken_s;
  assign bus.i_or_e_out               = i_or_e_r;
  assign bus.cause_out                = cause_r;
  assign bus.set_epc_out              = set_epc_s;
  assign bus.set_cause_out            = set_cause_s;
  assign bus.mie_clear_out            = mie_clear_s;
  assign bus.mie_set_out              = mie_set_s;
  assign bus.misaligned_exception_out = mis_exc_s;
  assign bus.instret_inc_out          = instret_inc_s;
  assign bus.pc_src_out               = pc_src_s;
  assign bus.flush_out                = flush_s;

endmodule

// File: tb/tb_machine_control_unit.sv
// Directed self-checking bench for machine_control_unit. Interrupt/WFI
// scenarios run only when MCU_INTERRUPTS_EN is defined.
module tb_machine_control_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   fails  = 0;

  machine_control_unit_if ifc ();

  machine_control_unit dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    ifc.illegal_instr_in    = 1'b0;
    ifc.misaligned_instr_in = 1'b0;
    ifc.misaligned_load_in  = 1'b0;
    ifc.misaligned_store_in = 1'b0;
    ifc.ecall_in            = 1'b0;
    ifc.ebreak_in           = 1'b0;
    ifc.mret_in             = 1'b0;
    ifc.wfi_in              = 1'b0;
`ifdef MCU_INTERRUPTS_EN
    ifc.mie_in  = 1'b0;
    ifc.meie_in = 1'b0; ifc.mtie_in = 1'b0; ifc.msie_in = 1'b0;
    ifc.meip_in = 1'b0; ifc.mtip_in = 1'b0; ifc.msip_in = 1'b0;
`endif
  endtask

  // Checks of the one-cycle TRAP_TAKEN strobe set
  task automatic chk_trap(input string tag, input logic [3:0] cause, input logic ioe, input logic mis);
    chk({tag, "_set_epc"}, 32'(ifc.set_epc_out), 32'd1);
    chk({tag, "_set_cause"}, 32'(ifc.set_cause_out), 32'd1);
    chk({tag, "_mie_clear"}, 32'(ifc.mie_clear_out), 32'd1);
    chk({tag, "_pc_src"}, 32'(ifc.pc_src_out), 32'd2);
    chk({tag, "_flush"}, 32'(ifc.flush_out), 32'd1);
    chk({tag, "_cause"}, 32'(ifc.cause_out), 32'(cause));
    chk({tag, "_i_or_e"}, 32'(ifc.i_or_e_out), 32'(ioe));
    chk({tag, "_mis"}, 32'(ifc.misaligned_exception_out), 32'(mis));
    chk({tag, "_trap_taken"}, 32'(ifc.trap_taken_out), 32'd0);
  endtask

  task automatic chk_oper(input string tag);
    chk({tag, "_pc_src"}, 32'(ifc.pc_src_out), 32'd3);
    chk({tag, "_flush"}, 32'(ifc.flush_out), 32'd0);
    chk({tag, "_set_epc"}, 32'(ifc.set_epc_out), 32'd0);
    chk({tag, "_mie_set"}, 32'(ifc.mie_set_out), 32'd0);
  endtask

  initial begin
    clear_in();
    // Reset state
    #12;
    chk("rst_pc_src", 32'(ifc.pc_src_out), 32'd0);
    chk("rst_flush", 32'(ifc.flush_out), 32'd1);
    chk("rst_cause", 32'(ifc.cause_out), 32'd0);
    chk("rst_i_or_e", 32'(ifc.i_or_e_out), 32'd0);
    chk("rst_instret", 32'(ifc.instret_inc_out), 32'd0);
    chk("rst_set_epc", 32'(ifc.set_epc_out), 32'd0);
    chk("rst_trap_taken", 32'(ifc.trap_taken_out), 32'd0);
    rst_n = 1'b1;
    #2;
    chk("boot_pc_src", 32'(ifc.pc_src_out), 32'd0);
    chk("boot_flush", 32'(ifc.flush_out), 32'd1);
    tick();
    chk_oper("op0");
    chk("op0_instret", 32'(ifc.instret_inc_out), 32'd1);

    // Misaligned store trap
    ifc.misaligned_store_in = 1'b1;
    #1;
    chk("st_trap_taken", 32'(ifc.trap_taken_out), 32'd1);
    chk("st_instret", 32'(ifc.instret_inc_out), 32'd0);
    tick();
    clear_in();
    chk_trap("st", 4'd6, 1'b0, 1'b1);
    tick();
    chk_oper("st_back");
    chk("st_cause_hold", 32'(ifc.cause_out), 32'd6);

    // Illegal + ECALL: illegal wins
    ifc.illegal_instr_in = 1'b1;
    ifc.ecall_in = 1'b1;
    #1;
    chk("ill_trap_taken", 32'(ifc.trap_taken_out), 32'd1);
    tick();
    clear_in();
    chk_trap("ill", 4'd2, 1'b0, 1'b0);
    tick();
    // MRET
    ifc.mret_in = 1'b1;
    #1;
    chk("mret_trap_taken", 32'(ifc.trap_taken_out), 32'd0);
    chk("mret_instret", 32'(ifc.instret_inc_out), 32'd1);
    tick();
    ifc.mret_in = 1'b0;
    ifc.ecall_in = 1'b1;   // must be ignored outside OPERATING
    #1;
    chk("ret_mie_set", 32'(ifc.mie_set_out), 32'd1);
    chk("ret_pc_src", 32'(ifc.pc_src_out), 32'd1);
    chk("ret_flush", 32'(ifc.flush_out), 32'd1);
    chk("ret_trap_taken", 32'(ifc.trap_taken_out), 32'd0);
    chk("ret_set_epc", 32'(ifc.set_epc_out), 32'd0);
    chk("ret_cause_hold", 32'(ifc.cause_out), 32'd2);
    tick();
    clear_in();
    chk_oper("ret_back");
    chk("ret_back_cause", 32'(ifc.cause_out), 32'd2);

    // Misaligned fetch together with MRET: trap cause 0, mret dropped
    ifc.misaligned_instr_in = 1'b1;
    ifc.mret_in = 1'b1;
    ifc.illegal_instr_in = 1'b1;
    tick();
    clear_in();
    chk_trap("mif", 4'd0, 1'b0, 1'b1);
    chk("mif_mie_set", 32'(ifc.mie_set_out), 32'd0);
    tick();

    // EBREAK beats ECALL
    ifc.ebreak_in = 1'b1;
    ifc.ecall_in = 1'b1;
    ifc.misaligned_load_in = 1'b1;
    tick();
    clear_in();
    chk_trap("ebk", 4'd3, 1'b0, 1'b0);
    tick();

    // ECALL beats misaligned load
    ifc.ecall_in = 1'b1;
    ifc.misaligned_load_in = 1'b1;
    tick();
    clear_in();
    chk_trap("ecl", 4'd11, 1'b0, 1'b0);
    tick();

    // Misaligned load beats misaligned store
    ifc.misaligned_load_in = 1'b1;
    ifc.misaligned_store_in = 1'b1;
    tick();
    clear_in();
    chk_trap("ld", 4'd4, 1'b0, 1'b1);
    tick();

`ifndef MCU_INTERRUPTS_EN
    // WFI is a NOP without interrupt support
    ifc.wfi_in = 1'b1;
    #1;
    chk("wfi_nop_instret", 32'(ifc.instret_inc_out), 32'd1);
    tick();
    clear_in();
    chk_oper("wfi_nop");
`else
    // Interrupt beats exception; MEI over MTI
    ifc.mie_in = 1'b1;
    ifc.meie_in = 1'b1; ifc.meip_in = 1'b1;
    ifc.mtie_in = 1'b1; ifc.mtip_in = 1'b1;
    ifc.illegal_instr_in = 1'b1;
    #1;
    chk("irq_trap_taken", 32'(ifc.trap_taken_out), 32'd1);
    tick();
    clear_in();
    chk_trap("irq", 4'd11, 1'b1, 1'b0);
    tick();

    // WFI wait then wake with MIE clear
    ifc.wfi_in = 1'b1;
    #1;
    chk("wfi_instret0", 32'(ifc.instret_inc_out), 32'd0);
    tick();
    clear_in();
    for (int i = 0; i < 5; i++) begin
      chk("wfi_flush", 32'(ifc.flush_out), 32'd1);
      chk("wfi_instret", 32'(ifc.instret_inc_out), 32'd0);
      chk("wfi_pc_src", 32'(ifc.pc_src_out), 32'd3);
      tick();
    end
    ifc.mtie_in = 1'b1;
    ifc.mtip_in = 1'b1;
    #1;
    chk("wake_trap_taken", 32'(ifc.trap_taken_out), 32'd0);
    tick();
    chk_oper("wake");
    chk("wake_no_trap", 32'(ifc.trap_taken_out), 32'd0);
    clear_in();
    tick();
`endif

    // Reset during TRAP_TAKEN
    ifc.illegal_instr_in = 1'b1;
    tick();
    clear_in();
    chk("mid_set_epc_pre", 32'(ifc.set_epc_out), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_set_epc", 32'(ifc.set_epc_out), 32'd0);
    chk("mid_set_cause", 32'(ifc.set_cause_out), 32'd0);
    chk("mid_mie_clear", 32'(ifc.mie_clear_out), 32'd0);
    chk("mid_cause", 32'(ifc.cause_out), 32'd0);
    chk("mid_pc_src", 32'(ifc.pc_src_out), 32'd0);
    chk("mid_flush", 32'(ifc.flush_out), 32'd1);
    #1;
    rst_n = 1'b1;
    #1;
    chk("mid_boot_pc_src", 32'(ifc.pc_src_out), 32'd0);
    tick();
    chk_oper("mid_back");
    chk("mid_back_instret", 32'(ifc.instret_inc_out), 32'd1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/machine_control_unit.md
Name: machine_control_unit

Overview:
- Trap/return sequencer for the RV32I core.
- Consumes the decoder's illegal/misaligned flags plus pre-decoded system instructions and, optionally, interrupt lines.
- Produces trap_taken (fed back to the decoder to suppress memory writes), PC-source select, pipeline flush and CSR update strobes (mepc, mcause, mstatus.MIE).
- Sits beside the decoder and CSR file in the execute stage.

Parameters:
- BOOT_PC_SEL, 2'b00, pc_src encoding for the boot/reset address.
- EPC_PC_SEL, 2'b01, pc_src encoding for mepc (MRET).
- TRAP_PC_SEL, 2'b10, pc_src encoding for the trap vector.
- NEXT_PC_SEL, 2'b11, pc_src encoding for sequential/branch PC.

Ports:
- clk_in  input  1  core clock
- rst_n_in  input  1  asynchronous active-low reset
- illegal_instr_in  input  1  decoder illegal instruction
- misaligned_instr_in  input  1  fetch target not 4-byte aligned
- misaligned_load_in  input  1  decoder misaligned load
- misaligned_store_in  input  1  decoder misaligned store
- ecall_in  input  1  current instruction is ECALL
- ebreak_in  input  1  current instruction is EBREAK
- mret_in  input  1  current instruction is MRET
- wfi_in  input  1  current instruction is WFI
- mie_in  input  1  mstatus.MIE (interrupt ports and WFI state exist only with MCU_INTERRUPTS_EN)
- meie_in, mtie_in, msie_in  input  1 each  mie enables
- meip_in, mtip_in, msip_in  input  1 each  pending external/timer/software interrupts
- trap_taken_out  output  1  trap accepted this cycle (combinational)
- i_or_e_out  output  1  registered: 1=interrupt, 0=exception
- cause_out  output  4  registered mcause code
- set_epc_out  output  1  write mepc
- set_cause_out  output  1  write mcause
- mie_clear_out  output  1  MPIE<=MIE, MIE<=0
- mie_set_out  output  1  MIE<=MPIE
- misaligned_exception_out  output  1  select mtval = faulting address
- instret_inc_out  output  1  minstret increment
- pc_src_out  output  2  PC mux select
- flush_out  output  1  squash the instruction in flight

Behaviour:
- States: RESET, OPERATING, TRAP_TAKEN, TRAP_RETURN, WFI_WAIT (WFI_WAIT only with macro).
- Async reset, in any state including mid-trap:
  - state=RESET; cause_out=0; i_or_e_out=0; misaligned flag=0.
  - In RESET: pc_src_out=BOOT_PC_SEL, flush_out=1; all other outputs 0.
- RESET -> OPERATING unconditionally on the next clock edge.
- Signal definitions:
  - exc = illegal | misaligned_instr | misaligned_load | misaligned_store | ecall | ebreak.
  - irq = mie & ((meie&meip) | (msie&msip) | (mtie&mtip)).
- OPERATING outputs:
  - pc_src_out=NEXT_PC_SEL; flush_out=0.
  - trap_taken_out = irq|exc, combinational in the same cycle, so the decoder blocks the store.
  - instret_inc_out = ~(irq|exc) & ~wfi.
- OPERATING transitions, priority order:
  - irq -> TRAP_TAKEN, i_or_e=1.
  - exc -> TRAP_TAKEN, i_or_e=0.
  - mret -> TRAP_RETURN.
  - wfi -> WFI_WAIT.
  - otherwise stay.
- Interrupt cause priority: MEI=11 > MSI=3 > MTI=7.
- Exception cause priority: misaligned_instr=0 > illegal=2 > ebreak=3 > ecall=11 > misaligned_load=4 > misaligned_store=6.
- Registers are latched on the OPERATING->TRAP_TAKEN edge: cause_out, i_or_e_out, misaligned flag (set when cause is 0, 4 or 6).
- TRAP_TAKEN (exactly 1 cycle):
  - Outputs: set_epc_out=1, set_cause_out=1, mie_clear_out=1, misaligned_exception_out=flag, pc_src_out=TRAP_PC_SEL, flush_out=1.
  - Next state: OPERATING.
- TRAP_RETURN (1 cycle):
  - Outputs: mie_set_out=1, pc_src_out=EPC_PC_SEL, flush_out=1.
  - Next state: OPERATING.
- WFI_WAIT:
  - Outputs: pc_src_out=NEXT_PC_SEL, flush_out=1, instret_inc_out=0.
  - Leaves for OPERATING when (meie&meip)|(msie&msip)|(mtie&mtip), regardless of mie_in.
- All instruction inputs are ignored outside OPERATING.
- A misaligned instruction flagged together with mret gives a trap with cause 0; mret is dropped.
- cause_out holds its value until the next trap entry.

Optional Feature:
- Macro: MCU_INTERRUPTS_EN.
- Defined: interrupt ports, irq path, WFI_WAIT state and i_or_e_out=1 capability are present.
- Undefined: interrupt ports are absent; irq≡0; wfi acts as NOP (instret_inc_out=1); i_or_e_out is constant 0; no WFI_WAIT state.

Decomposition:
- Package mcu_pkg (shared with the CSR file): state encodings; cause code localparams (CAUSE_MISALIGNED_INSTR, CAUSE_ILLEGAL, CAUSE_EBREAK, CAUSE_MISALIGNED_LOAD, CAUSE_MISALIGNED_STORE, CAUSE_ECALL, CAUSE_MSI, CAUSE_MTI, CAUSE_MEI); PC_SEL encodings.
- Sub-module trap_cause_encoder: combinational priority encoder producing {valid, i_or_e, cause[3:0]} from the flag inputs.

Test Plan:
- Release reset -> one cycle pc_src=00, flush=1; then OPERATING with pc_src=11, instret_inc=1.
- misaligned_store_in=1 in OPERATING -> trap_taken_out=1 same cycle; next cycle set_epc=set_cause=mie_clear=1, cause_out=6, misaligned_exception_out=1, pc_src=10; then back to pc_src=11.
- illegal_instr_in and ecall_in together -> cause_out=2, i_or_e_out=0; mret_in next -> 1 cycle mie_set=1, pc_src=01, flush=1.
- MCU_INTERRUPTS_EN, mie=1, meie=meip=1, mtie=mtip=1, illegal=1 -> cause_out=11, i_or_e_out=1.
- MCU_INTERRUPTS_EN, wfi_in=1 -> WFI_WAIT with instret_inc=0, flush=1 for 5 cycles; assert mtip with mtie=1, mie=0 -> return to OPERATING, no trap.
- Assert rst_n_in low during TRAP_TAKEN -> all strobes drop immediately, cause_out=0; after release, RESET sequence repeats.
